ace_snoop_responder: RTL and testbench

Cache-side snoop engine attached to the Slave end of a snoop bus. Accepts one AC request at a time, looks the address up in the local cache tag/data array, returns the ACE CR response and, when required, streams the cache line as CD beats. It also issues the matching coherence-state update to the cache. One snoop is outstanding at a time; no AC is accepted until the previous snoop has fully completed.

---
 rtl/ace_snoop_responder.sv | 182 ++++++++++++++++++
 tb/tb_ace_snoop_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: takes one AC snoop at a time, looks it up in the local cache,
// and answers on CR, streams the line on CD and issues the cache state update.
module ace_snoop_responder #(
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int LineBeats = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           ac_valid_i,
   output logic                           ac_ready_o,
   input  logic [AddrWidth-1:0]           ac_addr_i,
   input  logic [3:0]                     ac_snoop_i,
   input  logic [2:0]                     ac_prot_i,
   output logic                           cr_valid_o,
   input  logic                           cr_ready_i,
   output logic [4:0]                     cr_resp_o,
   output logic                           cd_valid_o,
   input  logic                           cd_ready_i,
   output logic [DataWidth-1:0]           cd_data_o,
   output logic                           cd_last_o,
   output logic                           lu_valid_o,
   input  logic                           lu_ready_i,
   output logic [AddrWidth-1:0]           lu_addr_o,
   output logic [2:0]                     lu_prot_o,
   input  logic                           lu_rvalid_i,
   input  logic                           lu_hit_i,
   input  logic                           lu_dirty_i,
   input  logic                           lu_unique_i,
   input  logic [LineBeats*DataWidth-1:0] lu_line_i,
   output logic                           upd_valid_o,
   input  logic                           upd_ready_i,
   output logic [AddrWidth-1:0]           upd_addr_o,
   output logic                           upd_inval_o,
   output logic                           upd_shared_o,
   output logic                           upd_clean_o
);

   localparam int BeatW = (LineBeats > 1) ? $clog2(LineBeats) : 1;
   localparam logic [BeatW-1:0] LastBeat = BeatW'(LineBeats - 1);

   typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_RES, RESP} state_e;

   state_e state_q, state_d;

   logic [AddrWidth-1:0]                addr_q;
   logic [3:0]                          snoop_q;
   logic [2:0]                          prot_q;
   logic [LineBeats-1:0][DataWidth-1:0] line_q;
   logic [4:0]                          resp_q;
   logic [BeatW-1:0]                    beat_q;
   logic                                cr_pend_q, cd_pend_q, upd_pend_q;
   logic                                inval_q, shared_q, clean_q;

   // Response decode, valid only while the lookup result is on the bus
   logic [4:0] resp_d;
   logic       dt_d, upd_d, inval_d, shared_d, clean_d;
   logic       u, d;

   assign u = lu_unique_i;
   assign d = lu_dirty_i;

   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      resp_d   = '0;
      dt_d     = 1'b0;
      upd_d    = 1'b0;
      inval_d  = 1'b0;
      shared_d = 1'b0;
      clean_d  = 1'b0;
      if (lu_hit_i) begin
         case (snoop_q)
            4'b0000: begin resp_d = {u, 1'b1, 1'b0, 1'b0, 1'b1}; dt_d = 1'b1; end
            4'b0001: begin
               resp_d = {u, 1'b1, d, 1'b0, 1'b1}; dt_d = 1'b1;
               upd_d = 1'b1; shared_d = 1'b1; clean_d = d;
            end
            4'b0010, 4'b0011: begin
               resp_d = {u, 1'b1, 1'b0, 1'b0, 1'b1}; dt_d = 1'b1;
               upd_d = 1'b1; shared_d = 1'b1;
            end
            4'b0111: begin
               resp_d = {u, 1'b0, d, 1'b0, 1'b1}; dt_d = 1'b1;
               upd_d = 1'b1; inval_d = 1'b1;
            end
            4'b1001: begin
               resp_d = {u, 1'b0, d, 1'b0, d}; dt_d = d;
               upd_d = 1'b1; inval_d = 1'b1;
            end
            4'b1000: begin
               resp_d = {u, 1'b1, d, 1'b0, d}; dt_d = d;
               upd_d = d; clean_d = d;
            end
            4'b1101: begin resp_d = {u, 4'b0000}; upd_d = 1'b1; inval_d = 1'b1; end
            default: ;
         endcase
      end
   end

   // Per-channel handshakes in RESP; the snoop ends when all pending channels drain
   logic cr_hs, cd_hs, upd_hs;
   logic cr_pend_d, cd_pend_d, upd_pend_d;

   assign cr_hs      = cr_pend_q && cr_ready_i;
   assign cd_hs      = cd_pend_q && cd_ready_i;
   assign upd_hs     = upd_pend_q && upd_ready_i;
   assign cr_pend_d  = cr_pend_q && !cr_hs;
   assign cd_pend_d  = cd_pend_q && !(cd_hs && beat_q == LastBeat);
   assign upd_pend_d = upd_pend_q && !upd_hs;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (ac_valid_i) state_d = LOOKUP;
         LOOKUP:   if (lu_ready_i) state_d = WAIT_RES;
         WAIT_RES: if (lu_rvalid_i) state_d = RESP;
         RESP:     if (!cr_pend_d && !cd_pend_d && !upd_pend_d) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge value of its inputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         snoop_q    <= '0;
         prot_q     <= '0;
         // NOTE: the line buffer is reset because it drives cd_data_o directly,
         // which must read zero out of reset.
         line_q     <= '0;
         resp_q     <= '0;
         beat_q     <= '0;
         cr_pend_q  <= 1'b0;
         cd_pend_q  <= 1'b0;
         upd_pend_q <= 1'b0;
         inval_q    <= 1'b0;
         shared_q   <= 1'b0;
         clean_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && ac_valid_i) begin
            addr_q  <= ac_addr_i;
            snoop_q <= ac_snoop_i;
            prot_q  <= ac_prot_i;
         end
         if (state_q == WAIT_RES && lu_rvalid_i) begin
            line_q     <= lu_line_i;
            resp_q     <= resp_d;
            beat_q     <= '0;
            cr_pend_q  <= 1'b1;
            cd_pend_q  <= dt_d;
            upd_pend_q <= upd_d;
            inval_q    <= inval_d;
            shared_q   <= shared_d;
            clean_q    <= clean_d;
         end else if (state_q == RESP) begin
            cr_pend_q  <= cr_pend_d;
            cd_pend_q  <= cd_pend_d;
            upd_pend_q <= upd_pend_d;
            if (cd_hs && beat_q != LastBeat) beat_q <= beat_q + 1'b1;
         end
      end
   end

   assign ac_ready_o   = (state_q == IDLE);
   assign lu_valid_o   = (state_q == LOOKUP);
   assign lu_addr_o    = addr_q;
   assign lu_prot_o    = prot_q;
   assign cr_valid_o   = cr_pend_q;
   assign cr_resp_o    = resp_q;
   assign cd_valid_o   = cd_pend_q;
   assign cd_data_o    = line_q[beat_q];
   assign cd_last_o    = cd_pend_q && (beat_q == LastBeat);
   assign upd_valid_o  = upd_pend_q;
   assign upd_addr_o   = addr_q;
   assign upd_inval_o  = inval_q;
   assign upd_shared_o = shared_q;
   assign upd_clean_o  = clean_q;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed self-checking bench for ace_snoop_responder: one snoop per test-plan vector.
module tb_ace_snoop_responder;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int LB = 4;

   typedef logic [LB*DW-1:0] line_t;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          ac_valid_i = 1'b0;
   logic          ac_ready_o;
   logic [AW-1:0] ac_addr_i = '0;
   logic [3:0]    ac_snoop_i = '0;
   logic [2:0]    ac_prot_i = '0;
   logic          cr_valid_o;
   logic          cr_ready_i = 1'b0;
   logic [4:0]    cr_resp_o;
   logic          cd_valid_o;
   logic          cd_ready_i = 1'b0;
   logic [DW-1:0] cd_data_o;
   logic          cd_last_o;
   logic          lu_valid_o;
   logic          lu_ready_i = 1'b0;
   logic [AW-1:0] lu_addr_o;
   logic [2:0]    lu_prot_o;
   logic          lu_rvalid_i = 1'b0;
   logic          lu_hit_i = 1'b0;
   logic          lu_dirty_i = 1'b0;
   logic          lu_unique_i = 1'b0;
   line_t         lu_line_i = '0;
   logic          upd_valid_o;
   logic          upd_ready_i = 1'b0;
   logic [AW-1:0] upd_addr_o;
   logic          upd_inval_o;
   logic          upd_shared_o;
   logic          upd_clean_o;

   int checks = 0;
   int errors = 0;

   ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineBeats(LB)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
      .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
      .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
      .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
      .cd_last_o(cd_last_o),
      .lu_valid_o(lu_valid_o), .lu_ready_i(lu_ready_i), .lu_addr_o(lu_addr_o),
      .lu_prot_o(lu_prot_o), .lu_rvalid_i(lu_rvalid_i), .lu_hit_i(lu_hit_i),
      .lu_dirty_i(lu_dirty_i), .lu_unique_i(lu_unique_i), .lu_line_i(lu_line_i),
      .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_addr_o(upd_addr_o),
      .upd_inval_o(upd_inval_o), .upd_shared_o(upd_shared_o), .upd_clean_o(upd_clean_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives AC and the lookup side; returns at the first negedge inside RESP.
   task automatic snoop(input string tag, input logic [3:0] snp, input logic [AW-1:0] addr,
                        input logic hit, input logic dirty, input logic uniq, input line_t line);
      check({tag, " ac_ready idle"}, ac_ready_o, 1);
      ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = snp; ac_prot_i = 3'b101;
      @(negedge clk_i);
      ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
      check({tag, " lu_valid"}, lu_valid_o, 1);
      check({tag, " lu_addr"}, lu_addr_o, addr);
      check({tag, " lu_prot"}, lu_prot_o, 3'b101);
      check({tag, " ac_ready busy"}, ac_ready_o, 0);
      lu_ready_i = 1'b1;
      @(negedge clk_i);
      lu_ready_i = 1'b0;
      lu_rvalid_i = 1'b1; lu_hit_i = hit; lu_dirty_i = dirty; lu_unique_i = uniq;
      lu_line_i = line;
      @(negedge clk_i);
      lu_rvalid_i = 1'b0; lu_hit_i = 1'b0; lu_dirty_i = 1'b0; lu_unique_i = 1'b0;
      lu_line_i = '0;
   endtask

   // Runs the RESP phase with the given ready pattern and checks every handshake.
   task automatic run_resp(input string tag, input logic [AW-1:0] addr, input line_t line,
                           input logic [4:0] exp_resp, input logic exp_dt, input logic exp_upd,
                           input logic exp_inval, input logic exp_shared, input logic exp_clean,
                           input int cr_stall, input bit cd_toggle);
      int  cyc = 0, last_hs = 0, beats = 0, cr_done = 0, upd_done = 0;
      bit  stable_ok = 1'b1;
      logic [DW-1:0] beat_exp;
      check({tag, " cr_valid entry"}, cr_valid_o, 1);
      check({tag, " cd_valid entry"}, cd_valid_o, exp_dt);
      check({tag, " upd_valid entry"}, upd_valid_o, exp_upd);
      while (!ac_ready_o && cyc < 60) begin
         cr_ready_i  = (cyc >= cr_stall);
         cd_ready_i  = cd_toggle ? (cyc % 2 == 1) : 1'b1;
         upd_ready_i = 1'b1;
         #1;
         if (cr_valid_o && cr_resp_o !== exp_resp) stable_ok = 1'b0;
         if (cr_valid_o && cr_ready_i) begin
            cr_done++; last_hs = cyc;
            check({tag, " cr_resp"}, cr_resp_o, exp_resp);
         end
         if (cd_valid_o && cd_ready_i) begin
            beat_exp = line[beats*DW +: DW];
            check({tag, " cd_data"}, cd_data_o, beat_exp);
            check({tag, " cd_last"}, cd_last_o, beats == LB - 1);
            beats++; last_hs = cyc;
         end
         if (upd_valid_o && upd_ready_i) begin
            check({tag, " upd flags"}, {upd_inval_o, upd_shared_o, upd_clean_o},
                  {exp_inval, exp_shared, exp_clean});
            check({tag, " upd_addr"}, upd_addr_o, addr);
            upd_done++; last_hs = cyc;
         end
         @(negedge clk_i);
         cyc++;
      end
      cr_ready_i = 1'b0; cd_ready_i = 1'b0; upd_ready_i = 1'b0;
      check({tag, " completed in budget"}, cyc < 60, 1);
      check({tag, " idle one cycle after last hs"}, cyc - 1, last_hs);
      check({tag, " cr count"}, cr_done, 1);
      check({tag, " cd beats"}, beats, exp_dt ? LB : 0);
      check({tag, " upd count"}, upd_done, exp_upd ? 1 : 0);
      check({tag, " cr_resp stable"}, stable_ok, 1);
   endtask

   line_t line_a, line_b;

   initial begin
      line_a = {64'h44, 64'h33, 64'h22, 64'h11};
      line_b = {64'hDDDD_0004, 64'hCCCC_0003, 64'hBBBB_0002, 64'hAAAA_0001};

      #2;
      check("rst ac_ready", ac_ready_o, 1);
      check("rst valids", {lu_valid_o, cr_valid_o, cd_valid_o, upd_valid_o}, 4'b0000);
      check("rst cr_resp", cr_resp_o, 0);
      check("rst cd_data", cd_data_o, 0);
      check("rst cd_last", cd_last_o, 0);
      check("rst lu_addr", lu_addr_o, 0);
      check("rst lu_prot", lu_prot_o, 0);
      check("rst upd_addr", upd_addr_o, 0);
      check("rst upd flags", {upd_inval_o, upd_shared_o, upd_clean_o}, 3'b000);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Stray lookup result while idle must be ignored
      lu_rvalid_i = 1'b1; lu_hit_i = 1'b1;
      @(negedge clk_i);
      lu_rvalid_i = 1'b0; lu_hit_i = 1'b0;
      check("stray rvalid ac_ready", ac_ready_o, 1);
      check("stray rvalid cr_valid", cr_valid_o, 0);

      snoop("rs", 4'b0001, 64'h1000, 1, 1, 1, line_a);
      run_resp("rs", 64'h1000, line_a, 5'b11101, 1, 1, 0, 1, 1, 0, 0);

      snoop("mi", 4'b1101, 64'h2040, 0, 0, 0, line_a);
      run_resp("mi", 64'h2040, line_a, 5'b00000, 0, 0, 0, 0, 0, 0, 0);

      snoop("ru", 4'b0111, 64'h3080, 1, 1, 1, line_b);
      run_resp("ru", 64'h3080, line_b, 5'b10101, 1, 1, 1, 0, 0, 5, 1);

      snoop("cs", 4'b1000, 64'h40C0, 1, 0, 0, line_b);
      run_resp("cs", 64'h40C0, line_b, 5'b01000, 0, 0, 0, 0, 0, 0, 0);

      snoop("unk", 4'b0101, 64'h5100, 1, 1, 1, line_a);
      run_resp("unk", 64'h5100, line_a, 5'b00000, 0, 0, 0, 0, 0, 0, 0);

      // Reset in the middle of a CD burst, after beat 1 is accepted
      snoop("rst", 4'b0001, 64'h6140, 1, 1, 1, line_b);
      cr_ready_i = 1'b0; upd_ready_i = 1'b0; cd_ready_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      cd_ready_i = 1'b0;
      check("rst mid cd_data beat2", cd_data_o, 64'hCCCC_0003);
      rst_ni = 1'b0;
      #1;
      check("rst mid valids", {lu_valid_o, cr_valid_o, cd_valid_o, upd_valid_o}, 4'b0000);
      check("rst mid ac_ready", ac_ready_o, 1);
      check("rst mid cr_resp", cr_resp_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      snoop("ro", 4'b0000, 64'h7180, 1, 0, 0, line_a);
      run_resp("ro", 64'h7180, line_a, 5'b01001, 1, 0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
